// File: rtl/pe_group_acc_pkg.sv
// pe_pkg: shared encodings, FSM state type and helpers for the pe_group_acc block
package pe_pkg;
    localparam logic MODE_FULL  = 1'b0;
    localparam logic MODE_SPLIT = 1'b1;
    localparam logic RST_ACT    = 1'b0;

    typedef enum logic {IDLE = 1'b0, OPEN = 1'b1} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/pe_group_acc_if.sv
// pe_group_acc_if: beat/frame handshake and result bus of the PE group (sat_flag only with SATURATE_EN)
interface pe_group_acc_if #(
    parameter int LANES = 6,
    parameter int DW    = 8,
    parameter int SPLIT = 2,
    parameter int ACC_W = 24
);
    logic                   in_valid;
    logic                   in_last;
    logic                   mode;
    logic [LANES*DW-1:0]    ifmap;
    logic [LANES*DW-1:0]    weight;
    logic [SPLIT*ACC_W-1:0] sum_out;
    logic                   out_valid;
    logic                   busy;
    logic                   frame_done;
`ifdef SATURATE_EN
    logic                   sat_flag;
`endif

    modport master (
        output in_valid, in_last, mode, ifmap, weight,
        input  sum_out, out_valid, busy, frame_done
`ifdef SATURATE_EN
        , input sat_flag
`endif
    );

    modport slave (
        input  in_valid, in_last, mode, ifmap, weight,
        output sum_out, out_valid, busy, frame_done
`ifdef SATURATE_EN
        , output sat_flag
`endif
    );
endinterface

// File: rtl/pe_group_acc_mul_lane.sv
// pe_mul_lane: registered signed multiply lane; a zero activation freezes the operands and forces a zero product
module pe_mul_lane
    import pe_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    input  logic signed [DW-1:0]   a_i,
    input  logic signed [DW-1:0]   b_i,
    output logic signed [2*DW-1:0] prod_o
);
    localparam int PW = 2 * DW;

    logic signed [DW-1:0] a_q, b_q;
    logic                 zero_q;

    // capture operands only for non-zero activations so the multiplier inputs stay quiet on zeros
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACT) begin
            a_q    <= '0;
            b_q    <= '0;
            zero_q <= 1'b1;
        end else if (valid_i) begin
            zero_q <= (a_i == '0);
            if (a_i != '0) begin
                a_q <= a_i;
                b_q <= b_i;
            end
        end
    end

    assign prod_o = zero_q ? '0 : PW'(a_q) * PW'(b_q);
endmodule

// File: rtl/pe_group_acc.sv
// pe_group_acc: multiply / reduce / frame-accumulate PE group; define SATURATE_EN for clamping adds and sat_flag
module pe_group_acc
    import pe_pkg::*;
#(
    parameter int LANES = 6,
    parameter int DW    = 8,
    parameter int SPLIT = 2,
    parameter int ACC_W = 24
) (
    input  logic           clk,
    input  logic           rst,
    pe_group_acc_if.slave  bus
);
    localparam int GL = LANES / SPLIT;
    localparam int PW = 2 * DW;

    state_t                 state_q, state_d;
    logic                   frame_mode_q, beat_mode, first_beat;
    logic signed [PW-1:0]   prod [LANES];
    logic                   v1_q, last1_q, mode1_q, first1_q;
    logic signed [ACC_W-1:0] part_d [SPLIT];
    logic signed [ACC_W-1:0] part_q [SPLIT];
    logic                   v2_q, last2_q, first2_q;
    logic signed [ACC_W-1:0] acc_d [SPLIT];
    logic signed [ACC_W-1:0] acc_q [SPLIT];
    logic signed [ACC_W-1:0] base;
    logic [SPLIT*ACC_W-1:0] sum_d, sum_q;
    logic                   v3_q, ov_q, fd_q;
`ifdef SATURATE_EN
    localparam logic signed [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};
    logic signed [ACC_W:0]  wide;
    logic                   ovf, sat_hit, sat_any, sat_acc_q, sat_flag_q;
`endif

    // frame state register; the frame's mode is captured on its first beat
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACT) begin
            state_q      <= IDLE;
            frame_mode_q <= MODE_FULL;
        end else begin
            state_q <= state_d;
            if (bus.in_valid && first_beat) frame_mode_q <= bus.mode;
        end
    end

    // next frame state and the per-beat first/mode qualifiers
    always_comb begin
        first_beat = (state_q == IDLE);
        beat_mode  = first_beat ? bus.mode : frame_mode_q;
        state_d    = bus.in_valid ? (bus.in_last ? IDLE : OPEN) : state_q;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        pe_mul_lane #(.DW(DW)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .valid_i (bus.in_valid),
            .a_i     (bus.ifmap[i*DW +: DW]),
            .b_i     (bus.weight[i*DW +: DW]),
            .prod_o  (prod[i])
        );
    end

    // beat side-band travelling alongside the multiplier stage
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACT) begin
            v1_q     <= 1'b0;
            last1_q  <= 1'b0;
            mode1_q  <= MODE_FULL;
            first1_q <= 1'b0;
        end else begin
            v1_q <= bus.in_valid;
            if (bus.in_valid) begin
                last1_q  <= bus.in_last;
                mode1_q  <= beat_mode;
                first1_q <= first_beat;
            end
        end
    end

    // reduction: split mode sums each lane group, full mode folds every lane into partial 0
    always_comb begin
        for (int j = 0; j < SPLIT; j++) part_d[j] = '0;
        for (int i = 0; i < LANES; i++)
            part_d[(mode1_q == MODE_SPLIT) ? i / GL : 0] += ACC_W'(prod[i]);
    end

    // reduction stage register
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACT) begin
            v2_q     <= 1'b0;
            last2_q  <= 1'b0;
            first2_q <= 1'b0;
            part_q   <= '{default: '0};
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                last2_q  <= last1_q;
                first2_q <= first1_q;
                part_q   <= part_d;
            end
        end
    end

    // accumulator adds; the first beat of a frame starts from zero
    always_comb begin
        base  = '0;
        sum_d = '0;
`ifdef SATURATE_EN
        wide    = '0;
        ovf     = 1'b0;
        sat_hit = 1'b0;
`endif
        for (int j = 0; j < SPLIT; j++) begin
            base = first2_q ? '0 : acc_q[j];
`ifdef SATURATE_EN
            wide     = {base[ACC_W-1], base} + {part_q[j][ACC_W-1], part_q[j]};
            ovf      = wide[ACC_W] ^ wide[ACC_W-1];
            acc_d[j] = ovf ? (wide[ACC_W] ? SMIN : SMAX) : wide[ACC_W-1:0];
            sat_hit  = sat_hit | ovf;
`else
            acc_d[j] = base + part_q[j];
`endif
            sum_d[j*ACC_W +: ACC_W] = acc_d[j];
        end
`ifdef SATURATE_EN
        sat_any = (first2_q ? 1'b0 : sat_acc_q) | sat_hit;
`endif
    end

    // accumulator and result registers; sum_out is only refreshed when a frame closes
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACT) begin
            acc_q <= '{default: '0};
            sum_q <= '0;
            v3_q  <= 1'b0;
            ov_q  <= 1'b0;
            fd_q  <= 1'b0;
`ifdef SATURATE_EN
            sat_acc_q  <= 1'b0;
            sat_flag_q <= 1'b0;
`endif
        end else begin
            v3_q <= v2_q;
            ov_q <= v2_q && last2_q;
            fd_q <= ov_q;
            if (v2_q) acc_q <= acc_d;
            if (v2_q && last2_q) sum_q <= sum_d;
`ifdef SATURATE_EN
            if (v2_q) sat_acc_q <= sat_any;
            if (v2_q && last2_q) sat_flag_q <= sat_any;
`endif
        end
    end

    assign bus.sum_out    = sum_q;
    assign bus.out_valid  = ov_q;
    assign bus.frame_done = fd_q;
    assign bus.busy       = (state_q == OPEN) || v1_q || v2_q || v3_q;
`ifdef SATURATE_EN
    assign bus.sat_flag   = sat_flag_q;
`endif
endmodule

// File: tb/tb_pe_group_acc.sv
// tb_pe_group_acc: table vectors, directed multi-cycle sequences and randomized frames against a frame-level model
module tb_pe_group_acc;
    localparam int LANES = 6;
    localparam int DW    = 8;
    localparam int SPLIT = 2;
    localparam int ACC_W = 16;
    localparam int GL    = LANES / SPLIT;
    localparam int MAXV  = (1 << (ACC_W - 1)) - 1;

    typedef struct {
        int                     cyc;
        logic [SPLIT*ACC_W-1:0] val;
        bit                     sat;
    } exp_t;

    typedef struct {
        bit md;
        int a[6];
        int w[6];
        int e0;
        int e1;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    vec_t tbl[7];
    bit   m_open = 0;
    bit   m_mode = 0;
    bit   m_sat = 0;
    int   m_acc[SPLIT];
    logic prev_ov = 1'b0;
    logic [SPLIT*ACC_W-1:0] held = '0;

    pe_group_acc_if #(.LANES(LANES), .DW(DW), .SPLIT(SPLIT), .ACC_W(ACC_W)) bus ();

    pe_group_acc #(.LANES(LANES), .DW(DW), .SPLIT(SPLIT), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [LANES*DW-1:0] pk(input int a[6]);
        logic [LANES*DW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*DW +: DW] = a[i][DW-1:0];
        return r;
    endfunction

    function automatic logic [LANES*DW-1:0] all(input int v);
        return pk('{v, v, v, v, v, v});
    endfunction

    // one cycle of stimulus; valid beats also advance the frame model and queue the expected result
    task automatic drive(input bit v, input bit last, input bit md, input logic [LANES*DW-1:0] ifm,
                         input logic [LANES*DW-1:0] wt, input bit expl, input int e0, input int e1, input bit esat);
        exp_t e;
        int   part[SPLIT];
        bus.in_valid = v;
        bus.in_last  = last;
        bus.mode     = md;
        bus.ifmap    = ifm;
        bus.weight   = wt;
        if (v) begin
            if (!m_open) begin
                m_mode = md;
                m_acc  = '{default: 0};
                m_sat  = 0;
            end
            part = '{default: 0};
            for (int i = 0; i < LANES; i++)
                part[m_mode ? i / GL : 0] += int'($signed(ifm[i*DW +: DW])) * int'($signed(wt[i*DW +: DW]));
            for (int j = 0; j < SPLIT; j++) begin
                m_acc[j] += part[j];
`ifdef SATURATE_EN
                if (m_acc[j] > MAXV) begin m_acc[j] = MAXV; m_sat = 1; end
                if (m_acc[j] < -MAXV - 1) begin m_acc[j] = -MAXV - 1; m_sat = 1; end
`endif
            end
            if (last) begin
                e.cyc = cyc + 3;
                e.sat = expl ? esat : m_sat;
                for (int j = 0; j < SPLIT; j++) e.val[j*ACC_W +: ACC_W] = m_acc[j][ACC_W-1:0];
                if (expl) begin
                    e.val[0 +: ACC_W]     = e0[ACC_W-1:0];
                    e.val[ACC_W +: ACC_W] = e1[ACC_W-1:0];
                end
                exp_q.push_back(e);
                m_open = 0;
            end else m_open = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 0, 0, 0, 0);
    endtask

    function automatic int rnd();
        return ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 30)) - 15;
    endfunction

    // scoreboard: frame results, latency, hold behaviour and the frame_done echo
    always @(negedge clk) begin
        if (!rst) begin
            prev_ov = 1'b0;
            held    = '0;
        end else begin
            chk("frame_done", bus.frame_done, prev_ov);
            if (bus.out_valid) begin
                if (exp_q.size() == 0) chk("unexpected_out_valid", bus.out_valid, 1'b0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("latency", cyc, e.cyc);
                    chk("sum_out", bus.sum_out, e.val);
`ifdef SATURATE_EN
                    chk("sat_flag", bus.sat_flag, e.sat);
`endif
                    held = e.val;
                end
            end else chk("sum_out_hold", bus.sum_out, held);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_out_valid: expected at cycle %0d", exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            prev_ov = bus.out_valid;
        end
    end

    initial begin
        tbl[0] = '{0, '{3, 3, 3, 3, 3, 3}, '{-2, -2, -2, -2, -2, -2}, -36, 0};
        tbl[1] = '{1, '{1, 2, 3, 4, 5, 6}, '{1, 1, 1, 1, 1, 1}, 6, 15};
        tbl[2] = '{1, '{-128, 0, 0, 0, 0, 0}, '{-128, 100, 100, 100, 100, 100}, 16384, 0};
        tbl[3] = '{0, '{0, 0, 0, 0, 0, 0}, '{127, 127, 127, 127, 127, 127}, 0, 0};
        tbl[4] = '{0, '{127, -128, 1, -1, 2, -2}, '{1, 1, 1, 1, 1, 1}, -1, 0};
        tbl[5] = '{1, '{-1, -1, -1, -1, -1, -1}, '{5, 5, 5, 7, 7, 7}, -15, -21};
        tbl[6] = '{0, '{10, 10, 10, 10, 10, 10}, '{-10, -10, -10, -10, -10, -10}, -600, 0};
        m_acc = '{default: 0};
        bus.in_valid = 0;
        bus.in_last  = 0;
        bus.mode     = 0;
        bus.ifmap    = '0;
        bus.weight   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_sum_out", bus.sum_out, '0);
        chk("reset_out_valid", bus.out_valid, 1'b0);
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_frame_done", bus.frame_done, 1'b0);
        rst = 1;
        idle(2);

        for (int k = 0; k < 7; k++) begin
            drive(1, 1, tbl[k].md, pk(tbl[k].a), pk(tbl[k].w), 1, tbl[k].e0, tbl[k].e1, 0);
            chk("busy_pipe", bus.busy, 1'b1);
            idle(4);
            chk("busy_idle", bus.busy, 1'b0);
        end

        drive(1, 0, 0, all(7), all(7), 0, 0, 0, 0);
        bus.in_valid = 0;
        rst = 0;
        #1;
        chk("midrst_sum_out", bus.sum_out, '0);
        chk("midrst_out_valid", bus.out_valid, 1'b0);
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_frame_done", bus.frame_done, 1'b0);
        @(posedge clk);
        #1;
        rst = 1;
        m_open = 0;
        idle(6);
        chk("midrst_busy_after", bus.busy, 1'b0);

        drive(1, 0, 0, all(10), all(5), 0, 0, 0, 0);
        drive(1, 0, 0, all(10), all(5), 0, 0, 0, 0);
        idle(1);
        chk("gap_busy", bus.busy, 1'b1);
        idle(1);
        drive(1, 0, 1, all(10), all(5), 0, 0, 0, 0);
        drive(1, 1, 1, all(10), all(5), 1, 1200, 0, 0);
        idle(5);

        drive(1, 1, 0, all(1), all(1), 1, 6, 0, 0);
        drive(1, 1, 0, all(2), all(1), 1, 12, 0, 0);
        idle(5);

        repeat (7) drive(1, 0, 0, all(127), all(127), 0, 0, 0, 0);
`ifdef SATURATE_EN
        drive(1, 1, 0, all(127), all(127), 1, 32767, 0, 1);
`else
        drive(1, 1, 0, all(127), all(127), 1, -12240, 0, 0);
`endif
        idle(5);

        for (int f = 0; f < 40; f++) begin
            int nb;
            bit md;
            nb = $urandom_range(1, 5);
            md = 1'($urandom);
            for (int b = 0; b < nb; b++) begin
                if (b > 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                drive(1, b == nb - 1, (b == 0) ? md : 1'($urandom),
                      pk('{rnd(), rnd(), rnd(), rnd(), rnd(), rnd()}),
                      pk('{rnd(), rnd(), rnd(), rnd(), rnd(), rnd()}), 0, 0, 0, 0);
            end
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(6);
        chk("queue_drained", exp_q.size(), 0);
        chk("final_busy", bus.busy, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pe_group_acc.md
Name: pe_group_acc

Overview:
Parametrised successor of the six-lane PE group: LANES signed multipliers with zero-skip, a reduction tree that is switchable between one full sum and SPLIT independent partial sums, and a per-output accumulator that sums over a multi-beat frame. It sits between the ifmap/weight broadcast logic and the writeback unit. It replaces fixed layer decoding with an explicit mode input and a valid/last frame handshake.

Parameters:
LANES, 6, number of multiply lanes; must be divisible by SPLIT.
DW, 8, signed width of each ifmap and weight element.
SPLIT, 2, number of partial sums produced in split mode.
ACC_W, 24, signed accumulator and output width; must be at least 2*DW+clog2(LANES).

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active low
in_valid  in  1  beat valid; ifmap, weight and in_last are sampled when this is high
in_last  in  1  final beat of the current frame
mode  in  1  0 = full sum of all lanes into out lane 0; 1 = SPLIT partial sums
ifmap  in  LANES*DW  packed signed activations; lane i is at [i*DW +: DW]
weight  in  LANES*DW  packed signed weights, same packing as ifmap
sum_out  out  SPLIT*ACC_W  packed signed frame results; lane j is at [j*ACC_W +: ACC_W]
out_valid  out  1  one-cycle pulse: sum_out holds a finished frame
busy  out  1  high while a frame is open or the pipeline still holds beats
frame_done  out  1  registered copy of out_valid, delayed one cycle (writeback completion strobe)

Behaviour:
- Reset (rst=0, asynchronous): every pipeline register, accumulator and valid bit is cleared. sum_out=0, out_valid=0, busy=0, frame_done=0, FSM=IDLE.
- Stage 1 (P): for each lane, prod_i = ifmap_i * weight_i, signed, 2*DW bits wide. If ifmap_i==0, prod_i is forced to 0 and the multiplier operands are held (power gating). v1 <= in_valid; last and mode travel with the beat.
- Stage 2 (R): group j sums lanes j*(LANES/SPLIT) through (j+1)*(LANES/SPLIT)-1, sign-extended to ACC_W. In mode 0, partial 0 is the sum of all groups and partials 1 to SPLIT-1 are 0.
- Stage 3 (A): on a valid beat, acc_j <= (first beat of frame ? 0 : acc_j) + partial_j. Addition wraps modulo 2^ACC_W unless SATURATE_EN is defined.
- On a valid beat with last=1: sum_out <= the new acc values and out_valid pulses for one cycle. sum_out holds its value until the next frame completes.
- Latency: a single-beat frame gives out_valid 3 cycles after the in_valid edge. An N-beat frame gives out_valid 3 cycles after its last beat.
- Throughput: one beat per cycle, with no bubbles between frames. A frame may start the cycle after the previous frame's last beat.
- FSM states are IDLE and OPEN.
  - IDLE -> OPEN: in_valid=1 and in_last=0. mode is latched as frame_mode.
  - OPEN -> IDLE: in_valid=1 and in_last=1.
  - IDLE with in_valid=1 and in_last=1: single-beat frame; the FSM stays in IDLE.
- mode is sampled only on a frame's first beat. Changes to mode while OPEN are ignored for the rest of that frame.
- in_valid=0 while OPEN is a gap: the accumulators hold and there is no timeout.
- busy = (state==OPEN) OR v1 OR v2 OR v3.
- Reset asserted mid-frame: the partial frame is discarded and no out_valid is produced.

Optional Feature:
SATURATE_EN
- Defined: each accumulator add clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Output sat_flag (1 bit, registered, reset 0) is added; it is high alongside out_valid if any lane clamped during that frame.
- Undefined: the add wraps and the sat_flag port does not exist.

Decomposition:
- Shared package pe_pkg holds:
  - mode encodings MODE_FULL=0 and MODE_SPLIT=1;
  - FSM state typedef (IDLE, OPEN);
  - function clog2;
  - reset-polarity constant (asserted level 0).
- One sub-module, pe_mul_lane (DW), is natural: registered signed multiply with zero-skip gating, instantiated LANES times by generate.

Test Plan:
- Reset mid-frame: open a frame, assert rst=0 for 1 cycle -> all outputs 0 immediately, busy=0, no out_valid afterwards.
- Mode 0, one beat, ifmap all 3, weight all -2 -> 3 cycles later out_valid=1, sum_out lane0=-36, lane1=0.
- Mode 1, one beat, ifmap={1,2,3,4,5,6}, weight all 1 -> lane0=6, lane1=15.
- Mode 0, 4-beat frame with a 2-cycle in_valid gap after beat 2; each beat has ifmap=10 and weight=5 on all lanes -> single out_valid, lane0=1200; mode toggled on beat 3 has no effect.
- Back-to-back single-beat frames on consecutive cycles, values 1 then 2 (all lanes, weight 1, mode 0) -> out_valid on two consecutive cycles with lane0=6 then 12; frame_done follows each one cycle later.
- SATURATE_EN, ACC_W=16, 8-beat frame with ifmap=127 and weight=127 on all lanes -> lane0=32767 and sat_flag=1. Without the macro -> the wrapped value (774192 mod 65536, interpreted as signed) and no sat_flag.
